// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the core memory bus arbiter.
// Holds the FSM encoding, the starvation default and the pipeline stall/address-width constants.
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_IFU_ADDR = 3'd1,
        ARB_IFU_DATA = 3'd2,
        ARB_LSU_ADDR = 3'd3,
        ARB_LSU_DATA = 3'd4,
        ARB_DRAIN    = 3'd5
    } arb_state_t;

    localparam int ARB_STARVE_MAX = 4;

    // Pipeline-control stall encoding and fetch address width, shared with the rest of the core.
    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;
    localparam int   INST_ADDR_BUS = 32;

    function automatic int streak_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Winner select for the arbiter's IDLE cycle; purely combinational.
// LSU has priority unless the IFU has been starved; the IFU is never picked during a flush.
module mem_arb_pick #(
    parameter int STARVE_MAX = 4,
    parameter int STREAK_W   = 3
) (
    input  logic                ifu_req,
    input  logic                lsu_req,
    input  logic [STREAK_W-1:0] streak,
    input  logic                flush_i,
    output logic                grant_ifu,
    output logic                grant_lsu
);

    logic starved;

    assign starved   = (streak >= STREAK_W'(STARVE_MAX));
    assign grant_ifu = ifu_req & ~flush_i & (~lsu_req | starved);
    assign grant_lsu = lsu_req & ~grant_ifu;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and load/store, one outstanding transaction at a time.
// Latency: 3 cycles minimum request-to-rvalid; bus_req held until bus_gnt, requesters stall until rvalid.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = INST_ADDR_BUS,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    input  logic                flush_i,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                stallreq_ifu_o,
    output logic                stallreq_lsu_o
);

    localparam int STREAK_W = streak_width(STARVE_MAX);

    typedef struct packed {
        logic                req;
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] wstrb;
    } bus_cmd_t;

    arb_state_t          state;
    bus_cmd_t            cmd;
    logic [STREAK_W-1:0] streak;
    logic                kill;
    logic                grant_ifu;
    logic                grant_lsu;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .STREAK_W   (STREAK_W)
    ) u_pick (
        .ifu_req   (ifu_req),
        .lsu_req   (lsu_req),
        .streak    (streak),
        .flush_i   (flush_i),
        .grant_ifu (grant_ifu),
        .grant_lsu (grant_lsu)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            cmd    <= '0;
            streak <= '0;
            kill   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_ifu) begin
                        state <= ARB_IFU_ADDR;
                        cmd   <= '{req: 1'b1, we: 1'b0, addr: ifu_addr, wdata: '0, wstrb: '0};
                    end else if (grant_lsu) begin
                        state <= ARB_LSU_ADDR;
                        cmd   <= '{req: 1'b1, we: lsu_we, addr: lsu_addr,
                                   wdata: lsu_wdata, wstrb: lsu_wstrb};
                    end
                    // Streak counts only LSU wins that made a waiting fetch wait longer.
                    if (grant_ifu || !ifu_req)
                        streak <= '0;
                    else if (grant_lsu && streak != STREAK_W'(STARVE_MAX))
                        streak <= streak + 1'b1;
                end
                ARB_IFU_ADDR: begin
                    if (flush_i)
                        kill <= 1'b1;
                    if (bus_gnt) begin
                        cmd   <= '0;
                        state <= (kill || flush_i) ? ARB_DRAIN : ARB_IFU_DATA;
                    end
                end
                ARB_IFU_DATA: begin
                    if (bus_rvalid) begin
                        state <= ARB_IDLE;
                    end else if (flush_i) begin
                        state <= ARB_DRAIN;
                        kill  <= 1'b1;
                    end
                end
                ARB_LSU_ADDR: begin
                    if (bus_gnt) begin
                        cmd   <= '0;
                        state <= ARB_LSU_DATA;
                    end
                end
                ARB_LSU_DATA: begin
                    if (bus_rvalid)
                        state <= ARB_IDLE;
                end
                ARB_DRAIN: begin
                    if (bus_rvalid) begin
                        state <= ARB_IDLE;
                        kill  <= 1'b0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    cmd   <= '0;
                    kill  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req   = cmd.req;
    assign bus_we    = cmd.we;
    assign bus_addr  = cmd.addr;
    assign bus_wdata = cmd.wdata;
    assign bus_wstrb = cmd.wstrb;

    // Responses are forwarded in the cycle they arrive; a flushed fetch response is swallowed.
    assign ifu_rvalid = rst_n & (state == ARB_IFU_DATA) & bus_rvalid & ~flush_i;
    assign lsu_rvalid = rst_n & (state == ARB_LSU_DATA) & bus_rvalid;
    assign ifu_rdata  = ifu_rvalid ? bus_rdata : '0;
    assign lsu_rdata  = lsu_rvalid ? bus_rdata : '0;

    assign stallreq_ifu_o = (rst_n & ifu_req & ~ifu_rvalid) ? STOP : NO_STOP;
    assign stallreq_lsu_o = (rst_n & lsu_req & ~lsu_rvalid) ? STOP : NO_STOP;

`ifdef MEM_ARB_DEBUG
    always_ff @(posedge clk) begin
        if (rst_n)
            assert (!bus_rvalid || state == ARB_IFU_DATA || state == ARB_LSU_DATA ||
                    state == ARB_DRAIN)
                else $error("mem_bus_arbiter: bus_rvalid with no transaction outstanding");
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_rvalid;
    logic [63:0] ifu_rdata;
    logic        lsu_req;
    logic        lsu_we;
    logic [31:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic        lsu_rvalid;
    logic [63:0] lsu_rdata;
    logic        flush_i;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;
    logic        stallreq_ifu_o;
    logic        stallreq_lsu_o;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: who is waiting, and how many LSU wins a waiting fetch has sat through.
    logic        m_ifu_pend = 1'b0;
    logic [31:0] m_ifu_addr = '0;
    logic        m_lsu_pend = 1'b0;
    logic        m_lsu_we   = 1'b0;
    logic [31:0] m_lsu_addr = '0;
    logic [63:0] m_lsu_wdata = '0;
    logic [7:0]  m_lsu_wstrb = '0;
    int          m_lsu_run  = 0;

    mem_bus_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req        (ifu_req),
        .ifu_addr       (ifu_addr),
        .ifu_rvalid     (ifu_rvalid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req        (lsu_req),
        .lsu_we         (lsu_we),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wstrb      (lsu_wstrb),
        .lsu_rvalid     (lsu_rvalid),
        .lsu_rdata      (lsu_rdata),
        .flush_i        (flush_i),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata),
        .stallreq_ifu_o (stallreq_ifu_o),
        .stallreq_lsu_o (stallreq_lsu_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        ifu_req   = m_ifu_pend;
        ifu_addr  = m_ifu_addr;
        lsu_req   = m_lsu_pend;
        lsu_we    = m_lsu_we;
        lsu_addr  = m_lsu_addr;
        lsu_wdata = m_lsu_wdata;
        lsu_wstrb = m_lsu_wstrb;
    endtask

    task automatic new_lsu(input logic we, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wstrb);
        m_lsu_pend  = 1'b1;
        m_lsu_we    = we;
        m_lsu_addr  = addr;
        m_lsu_wdata = wdata;
        m_lsu_wstrb = wstrb;
    endtask

    // One complete transaction starting from an IDLE cycle: gd stall cycles before gnt,
    // rd wait cycles before the response; fl holds flush_i high after the IDLE cycle.
    task automatic serve(input int gd, input int rd, input logic [63:0] rsp,
                         input bit fl, output bit got_ifu);
        bit exp_ifu;
        exp_ifu = m_ifu_pend && (!m_lsu_pend || m_lsu_run >= STARVE);
        if (exp_ifu)
            m_lsu_run = 0;
        else if (m_ifu_pend)
            m_lsu_run = (m_lsu_run < STARVE) ? m_lsu_run + 1 : STARVE;
        else
            m_lsu_run = 0;
        got_ifu = 1'b0;

        tick();
        drive_reqs();
        flush_i = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
        chk("idle_bus_req", bus_req, 0);
        chk("idle_ifu_rvalid", ifu_rvalid, 0);
        chk("idle_lsu_rvalid", lsu_rvalid, 0);
        chk("idle_stall_ifu", stallreq_ifu_o, m_ifu_pend);
        chk("idle_stall_lsu", stallreq_lsu_o, m_lsu_pend);

        for (int i = 0; i <= gd; i++) begin
            tick();
            flush_i = fl;
            bus_gnt = (i == gd);
            #1;
            chk("addr_bus_req", bus_req, 1);
            chk("addr_bus_addr", bus_addr, exp_ifu ? m_ifu_addr : m_lsu_addr);
            chk("addr_bus_we", bus_we, exp_ifu ? 1'b0 : m_lsu_we);
            if (!exp_ifu) begin
                chk("addr_bus_wstrb", bus_wstrb, m_lsu_wstrb);
                chk("addr_bus_wdata", bus_wdata, m_lsu_wdata);
            end
        end

        for (int i = 0; i <= rd; i++) begin
            tick();
            bus_gnt    = 1'b0;
            bus_rvalid = (i == rd);
            bus_rdata  = (i == rd) ? rsp : {$urandom, $urandom};
            #1;
            chk("data_bus_req", bus_req, 0);
            chk("data_ifu_rvalid", ifu_rvalid, exp_ifu && i == rd);
            chk("data_lsu_rvalid", lsu_rvalid, !exp_ifu && i == rd);
            if (i == rd) begin
                got_ifu = ifu_rvalid;
                if (exp_ifu) begin
                    chk("ifu_rdata", ifu_rdata, rsp);
                    chk("rsp_stall_ifu", stallreq_ifu_o, 0);
                end else begin
                    chk("lsu_rdata", lsu_rdata, rsp);
                    chk("rsp_stall_lsu", stallreq_lsu_o, 0);
                end
            end
        end
        if (exp_ifu) m_ifu_pend = 1'b0;
        else         m_lsu_pend = 1'b0;
    endtask

    task automatic quiet_cycle();
        tick();
        drive_reqs();
        flush_i = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
    endtask

    initial begin
        bit got;

        rst_n = 1'b0; flush_i = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        drive_reqs();
        repeat (2) tick();
        #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        chk("rst_ifu_rvalid", ifu_rvalid, 0);
        chk("rst_lsu_rvalid", lsu_rvalid, 0);
        chk("rst_stall_ifu", stallreq_ifu_o, 0);
        rst_n = 1'b1;

        // Single fetch at minimum latency.
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0000;
        serve(0, 0, 64'hDEAD_BEEF, 0, got);
        chk("single_fetch_is_ifu", got, 1);
        quiet_cycle();
        m_lsu_run = 0;
        chk("single_stall_after", stallreq_ifu_o, 0);
        chk("single_bus_req_after", bus_req, 0);

        // Contention: LSU write first, then the fetch.
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0008;
        new_lsu(1'b1, 32'h0000_1000, 64'h1122_3344_5566_7788, 8'h0F);
        serve(1, 0, 64'h0, 0, got);
        chk("contention_first_lsu", got, 0);
        serve(0, 1, 64'hCAFE_F00D_0000_0001, 0, got);
        chk("contention_second_ifu", got, 1);

        // Starvation: both always requesting -> LLLLI repeating.
        for (int k = 0; k < 10; k++) begin
            if (!m_ifu_pend) begin m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_1000 + 32'(k * 8); end
            if (!m_lsu_pend) new_lsu(1'b0, 32'h0000_2000 + 32'(k * 8), 64'h0, 8'h00);
            serve(0, 0, {32'hA5A5_0000, 32'(k)}, 0, got);
            chk("starve_grant_is_ifu", got, (k % 5) == 4);
        end
        serve(0, 0, 64'h55, 0, got);
        chk("starve_tail_lsu", got, 0);

        // A fetch is never granted in a flush cycle.
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0080;
        tick(); drive_reqs(); flush_i = 1'b1; bus_gnt = 1'b0; bus_rvalid = 1'b0; #1;
        chk("flush_idle_stall", stallreq_ifu_o, 1);
        serve(0, 0, 64'h80, 0, got);
        chk("flush_idle_then_ifu", got, 1);

        // Flush in IFU_ADDR with gnt three cycles late: response must be dropped.
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0040;
        tick(); drive_reqs(); flush_i = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; #1;
        chk("fa_idle_req", bus_req, 0);
        tick(); flush_i = 1'b1; #1;
        chk("fa_req_c1", bus_req, 1);
        chk("fa_addr", bus_addr, 32'h8000_0040);
        tick(); flush_i = 1'b0; m_ifu_pend = 1'b0; ifu_req = 1'b0; #1;
        chk("fa_req_c2", bus_req, 1);
        chk("fa_stall_dropped", stallreq_ifu_o, 0);
        tick(); #1;
        chk("fa_req_c3", bus_req, 1);
        tick(); bus_gnt = 1'b1; #1;
        chk("fa_req_c4", bus_req, 1);
        tick(); bus_gnt = 1'b0; #1;
        chk("fa_drain_req", bus_req, 0);
        chk("fa_drain_rvalid", ifu_rvalid, 0);
        tick(); bus_rvalid = 1'b1; bus_rdata = 64'h0BAD; #1;
        chk("fa_discard", ifu_rvalid, 0);
        chk("fa_discard_lsu", lsu_rvalid, 0);
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0100; m_lsu_run = 0;
        serve(0, 0, 64'h0100_0100, 0, got);
        chk("fa_refetch_ifu", got, 1);

        // Flush in IFU_DATA with the fetch still requesting: stall holds through DRAIN.
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0180;
        tick(); drive_reqs(); flush_i = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; #1;
        tick(); bus_gnt = 1'b1; #1;
        chk("fd_addr_req", bus_req, 1);
        tick(); bus_gnt = 1'b0; flush_i = 1'b1; #1;
        chk("fd_data_rvalid", ifu_rvalid, 0);
        tick(); flush_i = 1'b0; m_ifu_addr = 32'h8000_0200; ifu_addr = m_ifu_addr; #1;
        chk("fd_drain_stall", stallreq_ifu_o, 1);
        chk("fd_drain_req", bus_req, 0);
        tick(); bus_rvalid = 1'b1; bus_rdata = 64'h0BAD_0BAD; #1;
        chk("fd_drain_discard", ifu_rvalid, 0);
        chk("fd_drain_stall_rsp", stallreq_ifu_o, 1);
        serve(0, 0, 64'h0200_0200, 0, got);
        chk("fd_refetch_ifu", got, 1);

        // Flush coinciding with the response in IFU_DATA: dropped, straight back to IDLE.
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0280;
        tick(); drive_reqs(); flush_i = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; #1;
        tick(); bus_gnt = 1'b1; #1;
        tick(); bus_gnt = 1'b0; flush_i = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h77; #1;
        chk("fr_suppressed", ifu_rvalid, 0);
        m_ifu_addr = 32'h8000_0300;
        serve(2, 0, 64'h0300_0300, 0, got);
        chk("fr_refetch_ifu", got, 1);

        // LSU read with flush asserted throughout still completes.
        new_lsu(1'b0, 32'h0000_3000, 64'h0, 8'h00);
        serve(1, 2, 64'h0123_4567_89AB_CDEF, 1, got);
        chk("lsu_flush_completes", got, 0);

        // Synchronous reset in IFU_DATA.
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0380;
        tick(); drive_reqs(); flush_i = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; #1;
        tick(); bus_gnt = 1'b1; #1;
        tick(); bus_gnt = 1'b0; rst_n = 1'b0; #1;
        tick(); rst_n = 1'b1; m_ifu_pend = 1'b0; drive_reqs(); #1;
        m_lsu_run = 0;
        chk("rstd_bus_req", bus_req, 0);
        chk("rstd_bus_addr", bus_addr, 0);
        chk("rstd_bus_we", bus_we, 0);
        chk("rstd_ifu_rvalid", ifu_rvalid, 0);
        chk("rstd_lsu_rvalid", lsu_rvalid, 0);
        chk("rstd_stall_ifu", stallreq_ifu_o, 0);
        chk("rstd_stall_lsu", stallreq_lsu_o, 0);
        m_ifu_pend = 1'b1; m_ifu_addr = 32'h8000_0400;
        serve(0, 0, 64'h0400_0400, 0, got);
        chk("rstd_refetch_ifu", got, 1);

        // Randomized traffic.
        for (int r = 0; r < 40; r++) begin
            if (!m_ifu_pend && $urandom_range(0, 1) == 1) begin
                m_ifu_pend = 1'b1;
                m_ifu_addr = $urandom;
            end
            if (!m_lsu_pend && $urandom_range(0, 2) != 0)
                new_lsu(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom},
                        8'($urandom_range(0, 255)));
            if (!m_ifu_pend && !m_lsu_pend) begin
                quiet_cycle();
                m_lsu_run = 0;
                chk("rand_gap_bus_req", bus_req, 0);
            end else begin
                serve($urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom}, 0, got);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
